// File: rtl/memory_requester.sv
// Single-outstanding memory requester: latches a request onto the memory bus, strobes mem_clock,
// waits SETTLE_CYCLES, and returns the captured result. Optional MEMORY_REQUESTER_ERROR_CHECK_EN adds rsp_error.
module memory_requester #(
    parameter int unsigned ADDRESS_BITS  = 8,
    parameter int unsigned INDEX_BITS    = 3,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_action,
    input  logic [ADDRESS_BITS-1:0] req_array,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic [DATA_BITS-1:0]    req_in,
    output logic                    mem_clock,
    output logic [7:0]              mem_action,
    output logic [ADDRESS_BITS-1:0] mem_array,
    output logic [INDEX_BITS-1:0]   mem_index,
    output logic [DATA_BITS-1:0]    mem_in,
    input  logic [DATA_BITS-1:0]    mem_out,
    input  logic [31:0]             mem_error,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_BITS-1:0]    rsp_data,
    output logic                    rsp_error,
    output logic [15:0]             count
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STROBE  = 2'd1;
    localparam logic [1:0] SETTLE  = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    logic [1:0]              state_q,      state_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic                    req_ready_q,  req_ready_d;
    logic                    mem_clock_q,  mem_clock_d;
    logic [7:0]              mem_action_q, mem_action_d;
    logic [ADDRESS_BITS-1:0] mem_array_q,  mem_array_d;
    logic [INDEX_BITS-1:0]   mem_index_q,  mem_index_d;
    logic [DATA_BITS-1:0]    mem_in_q,     mem_in_d;
    logic                    rsp_valid_q,  rsp_valid_d;
    logic [DATA_BITS-1:0]    rsp_data_q,   rsp_data_d;
    logic [15:0]             count_q,      count_d;
    logic                    capture;

    // Next-state and output logic; the payload registers only load on acceptance.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_clock_d  = mem_clock_q;
        mem_action_d = mem_action_q;
        mem_array_d  = mem_array_q;
        mem_index_d  = mem_index_q;
        mem_in_d     = mem_in_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        count_d      = count_q;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_action_d = req_action;
                    mem_array_d  = req_array;
                    mem_index_d  = req_index;
                    mem_in_d     = req_in;
                    state_d      = STROBE;
                end
            end
            STROBE: begin
                mem_clock_d = 1'b1;
                cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                state_d     = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    capture     = 1'b1;
                    rsp_data_d  = mem_out;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    mem_clock_d = 1'b0;
                    count_d     = count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered ready mirrors the state being entered, so it is high exactly in IDLE.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_clock_q  <= 1'b0;
            mem_action_q <= '0;
            mem_array_q  <= '0;
            mem_index_q  <= '0;
            mem_in_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            mem_clock_q  <= mem_clock_d;
            mem_action_q <= mem_action_d;
            mem_array_q  <= mem_array_d;
            mem_index_q  <= mem_index_d;
            mem_in_q     <= mem_in_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            count_q      <= count_d;
        end
    end

`ifdef MEMORY_REQUESTER_ERROR_CHECK_EN
    logic rsp_error_q, rsp_error_d;

    always_comb begin
        rsp_error_d = rsp_error_q;
        if (capture) begin
            rsp_error_d = (mem_error != 32'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_error_q <= 1'b0;
        end else begin
            rsp_error_q <= rsp_error_d;
        end
    end

    assign rsp_error = rsp_error_q;
`else
    logic unused_err;
    assign unused_err = (^mem_error) ^ capture;
    assign rsp_error  = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign mem_clock  = mem_clock_q;
    assign mem_action = mem_action_q;
    assign mem_array  = mem_array_q;
    assign mem_index  = mem_index_q;
    assign mem_in     = mem_in_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign count      = count_q;

endmodule

// File: tb/tb_memory_requester.sv
// Self-checking bench for memory_requester: a behavioural memory responder plus transaction-level
// expectations (latency, data routing, throughput, count, reset abort).
module tb_memory_requester;

    localparam int unsigned AB = 8;
    localparam int unsigned IB = 3;
    localparam int unsigned DB = 16;
    localparam int unsigned SC = 2;
`ifdef MEMORY_REQUESTER_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [7:0]    req_action = '0;
    logic [AB-1:0] req_array = '0;
    logic [IB-1:0] req_index = '0;
    logic [DB-1:0] req_in = '0;
    logic          mem_clock;
    logic [7:0]    mem_action;
    logic [AB-1:0] mem_array;
    logic [IB-1:0] mem_index;
    logic [DB-1:0] mem_in;
    logic [DB-1:0] mem_out;
    logic [31:0]   mem_error = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DB-1:0] rsp_data;
    logic          rsp_error;
    logic [15:0]   count;

    logic          use_fixed = 1'b0;
    logic [DB-1:0] fixed_out = '0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [15:0]   exp_count = '0;

    memory_requester #(
        .ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB), .SETTLE_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_action(req_action), .req_array(req_array), .req_index(req_index), .req_in(req_in),
        .mem_clock(mem_clock), .mem_action(mem_action), .mem_array(mem_array),
        .mem_index(mem_index), .mem_in(mem_in),
        .mem_out(mem_out), .mem_error(mem_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .count(count)
    );

    always #5 clock = ~clock;

    // Behavioural memory: result is a fixed mix of the whole request payload.
    function automatic logic [DB-1:0] mem_fn(input logic [7:0] a, input logic [AB-1:0] ar,
                                             input logic [IB-1:0] ix, input logic [DB-1:0] d);
        return ((d * 16'd3) ^ {ar, a}) + {13'd0, ix};
    endfunction

    assign mem_out = use_fixed ? fixed_out : mem_fn(mem_action, mem_array, mem_index, mem_in);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_payload();
        req_action = 8'($urandom);
        req_array  = AB'($urandom);
        req_index  = IB'($urandom);
        req_in     = DB'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        exp_count = 16'd0;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        n_cmp++;
        if ({rsp_valid, mem_clock, rsp_error} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got %b exp 000", {rsp_valid, mem_clock, rsp_error});
        end
        n_cmp++;
        if ({mem_action, mem_array, mem_index, mem_in} !== '0) begin
            n_bad++; $display("FAIL reset_mem_bus got %h exp 0", {mem_action, mem_array, mem_index, mem_in});
        end
        n_cmp++;
        if ({rsp_data, count} !== 32'd0) begin
            n_bad++; $display("FAIL reset_data_count got %h/%h exp 0/0", rsp_data, count);
        end
    endtask

    task automatic test_single();
        use_fixed = 1'b1; fixed_out = 16'd3;
        req_action = 8'd9; req_array = 8'd1; req_index = 3'd0; req_in = 16'd5;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({mem_action, mem_array, mem_in, mem_clock, req_ready} !== {8'd9, 8'd1, 16'd5, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL single_accept got act=%0d arr=%0d in=%0d mclk=%b rdy=%b exp 9 1 5 0 0",
                              mem_action, mem_array, mem_in, mem_clock, req_ready);
        end
        step();
        n_cmp++;
        if ({mem_clock, rsp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL single_strobe got mclk=%b rv=%b exp 1 0", mem_clock, rsp_valid);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_rsp got %b exp 0", rsp_valid); end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 16'd3}) begin
            n_bad++; $display("FAIL single_rsp got rv=%b data=%0d exp 1 3", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        n_cmp++;
        if ({count, rsp_valid, mem_clock, req_ready} !== {exp_count, 3'b001}) begin
            n_bad++; $display("FAIL single_done got cnt=%0d rv=%b mclk=%b rdy=%b exp %0d 0 0 1",
                              count, rsp_valid, mem_clock, req_ready, exp_count);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] a; logic [AB-1:0] ar; logic [IB-1:0] ix; logic [DB-1:0] d; logic [DB-1:0] exp_d;
        int w;
        rand_payload();
        a = req_action; ar = req_array; ix = req_index; d = req_in;
        exp_d = mem_fn(a, ar, ix, d);
        req_valid = 1'b1;
        step();
        rand_payload();  // a fresh payload with req_valid still high must be ignored
        w = 0;
        while (rsp_valid !== 1'b1 && w < 20) begin step(); w++; end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_timeout got rv=%b exp 1", rsp_valid); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if ({rsp_valid, rsp_data, req_ready, mem_action, mem_array, mem_index, mem_in}
                !== {1'b1, exp_d, 1'b0, a, ar, ix, d}) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d got rv=%b data=%h rdy=%b bus=%h/%h/%h/%h exp 1 %h 0 %h/%h/%h/%h",
                         i, rsp_valid, rsp_data, req_ready, mem_action, mem_array, mem_index, mem_in,
                         exp_d, a, ar, ix, d);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        n_cmp++;
        if (count !== exp_count) begin n_bad++; $display("FAIL bp_count got %0d exp %0d", count, exp_count); end
    endtask

    task automatic test_random();
        logic [DB-1:0] exp_d; logic exp_e; int lat; int bp;
        for (int t = 0; t < 8; t++) begin
            rand_payload();
            mem_error = ($urandom_range(0, 1) != 0) ? 32'($urandom) | 32'h100 : 32'd0;
            exp_d = mem_fn(req_action, req_array, req_index, req_in);
            exp_e = ERR_EN && (mem_error != 32'd0);
            bp = $urandom_range(0, 3);
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 20) begin step(); lat++; end
            n_cmp++;
            if (lat != SC + 1) begin n_bad++; $display("FAIL rand_latency t=%0d got %0d exp %0d", t, lat, SC + 1); end
            n_cmp++;
            if ({rsp_data, rsp_error} !== {exp_d, exp_e}) begin
                n_bad++; $display("FAIL rand_data t=%0d got %h/%b exp %h/%b", t, rsp_data, rsp_error, exp_d, exp_e);
            end
            for (int i = 0; i < bp; i++) step();
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            exp_count = exp_count + 16'd1;
            n_cmp++;
            if ({count, req_ready} !== {exp_count, 1'b1}) begin
                n_bad++; $display("FAIL rand_count t=%0d got %0d/%b exp %0d/1", t, count, req_ready, exp_count);
            end
        end
        mem_error = 32'd0;
    endtask

    task automatic test_error();
        logic [31:0] ev [2];
        ev[0] = 32'h1; ev[1] = 32'h0;
        for (int t = 0; t < 2; t++) begin
            mem_error = ev[t];
            rand_payload();
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            for (int i = 0; i < SC + 1; i++) step();
            n_cmp++;
            if ({rsp_valid, rsp_error} !== {1'b1, ERR_EN && (ev[t] != 32'd0)}) begin
                n_bad++; $display("FAIL error_flag err=%h got rv=%b re=%b exp 1 %b",
                                  ev[t], rsp_valid, rsp_error, ERR_EN && (ev[t] != 32'd0));
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            exp_count = exp_count + 16'd1;
        end
        mem_error = 32'd0;
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] expq [$];
        int n_acc, n_rsp, cyc, last_acc;
        logic acc, hs;
        n_acc = 0; n_rsp = 0; cyc = 0; last_acc = -1;
        rand_payload();
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        while (n_rsp < 4 && cyc < 100) begin
            acc = req_valid & req_ready;
            hs  = rsp_valid & rsp_ready;
            if (hs) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_rsp got data=%h exp none", rsp_data);
                end else if (rsp_data !== expq[0]) begin
                    n_bad++; $display("FAIL b2b_data n=%0d got %h exp %h", n_rsp, rsp_data, expq[0]);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                n_rsp++;
                exp_count = exp_count + 16'd1;
            end
            if (acc) begin
                expq.push_back(mem_fn(req_action, req_array, req_index, req_in));
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc != SC + 3) begin
                        n_bad++; $display("FAIL b2b_spacing got %0d exp %0d", cyc - last_acc, SC + 3);
                    end
                end
                last_acc = cyc;
            end
            step();
            cyc++;
            if (acc) begin
                n_acc++;
                if (n_acc < 4) rand_payload(); else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (n_rsp != 4) begin n_bad++; $display("FAIL b2b_responses got %0d exp 4", n_rsp); end
        n_cmp++;
        if (count !== exp_count) begin n_bad++; $display("FAIL b2b_count got %0d exp %0d", count, exp_count); end
    endtask

    task automatic test_reset_in_settle();
        reset = 1'b1; step(); reset = 1'b0;
        exp_count = 16'd0;
        rand_payload();
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        n_cmp++;
        if (mem_clock !== 1'b1) begin n_bad++; $display("FAIL rst_settle_pre got mclk=%b exp 1", mem_clock); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({rsp_valid, mem_clock, req_ready, count} !== {3'b001, exp_count}) begin
            n_bad++; $display("FAIL rst_settle got rv=%b mclk=%b rdy=%b cnt=%0d exp 0 0 1 %0d",
                              rsp_valid, mem_clock, req_ready, count, exp_count);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                n_bad++; $display("FAIL rst_settle_quiet cyc=%0d got rv=%b rdy=%b exp 0 1", i, rsp_valid, req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_random();
        test_error();
        test_back_to_back();
        test_reset_in_settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
